// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl_fsm -- IF/ID/EXE/MEM/WB control FSM with memory req/ready
// handshakes, wait-state timeout into sticky FAULT, and sticky HALT.
// Optional build macro: PERF_CNT_EN (cycle and retired-instruction counters).
// Revision: 1.0
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [2:0]       ins_class,
  input  logic [1:0]       br_type,
  input  logic             zero,
  input  logic             sign,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic             wb_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EXE   = 3'b010,
    S_MEM   = 3'b011,
    S_WB    = 3'b100,
    S_HALT  = 3'b101,
    S_FAULT = 3'b110
  } state_t;

  localparam logic [2:0] C_ALU_R  = 3'b000;
  localparam logic [2:0] C_ALU_I  = 3'b001;
  localparam logic [2:0] C_LOAD   = 3'b010;
  localparam logic [2:0] C_STORE  = 3'b011;
  localparam logic [2:0] C_BRANCH = 3'b100;
  localparam logic [2:0] C_JUMP   = 3'b101;
  localparam logic [2:0] C_JAL    = 3'b110;
  localparam logic [2:0] C_HALT   = 3'b111;

  localparam int              WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_waiting;
  logic              timed_out;
  logic              br_taken;

  assign mem_waiting = ((cur == S_IF) && !imem_ready) || ((cur == S_MEM) && !dmem_ready);
  assign timed_out   = (MEM_TIMEOUT != 0) && mem_waiting && (wait_cnt == TIMEOUT_V);
  // br_type[0] inverts the flag, br_type[1] selects sign over zero
  assign br_taken    = br_type[1] ? (sign ^ br_type[0]) : (zero ^ br_type[0]);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cur      <= S_IF;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= '0;
      else if (mem_waiting)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt       = cur;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 2'b00;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    wb_src    = 1'b0;
    case (cur)
      S_IF: begin
        if (imem_ready) begin
          ir_write = 1'b1;
          nxt      = S_ID;
        end else if (timed_out) begin
          nxt = S_FAULT;
        end
      end
      S_ID: begin
        case (ins_class)
          C_JUMP: begin
            pc_write = 1'b1;
            pc_sel   = 2'b10;
            nxt      = S_IF;
          end
          C_JAL: begin
            pc_write  = 1'b1;
            pc_sel    = 2'b10;
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            wb_src    = 1'b1;
            nxt       = S_IF;
          end
          C_HALT:  nxt = S_HALT;
          default: nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        case (ins_class)
          C_BRANCH: begin
            pc_write = 1'b1;
            pc_sel   = br_taken ? 2'b01 : 2'b00;
            nxt      = S_IF;
          end
          C_ALU_R, C_ALU_I: nxt = S_WB;
          C_LOAD, C_STORE:  nxt = S_MEM;
          default:          nxt = S_IF;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (ins_class == C_STORE) begin
            pc_write = 1'b1;
            nxt      = S_IF;
          end else begin
            nxt = S_WB;
          end
        end else if (timed_out) begin
          nxt = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (ins_class == C_ALU_R) ? 2'b01 : 2'b00;
        pc_write  = 1'b1;
        nxt       = S_IF;
      end
      S_HALT:  nxt = S_HALT;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IF;
    endcase
  end

  assign imem_req = (cur == S_IF);
  assign dmem_req = (cur == S_MEM);
  assign dmem_we  = (cur == S_MEM) && (ins_class == C_STORE);
  assign state    = cur;
  assign halted   = (cur == S_HALT);
  assign fault    = (cur == S_FAULT);

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if ((cur != S_HALT) && (cur != S_FAULT))
        cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_write)
        retired_cnt <= retired_cnt + 1'b1;
    end
  end
`else
  generate
    if (1) begin : g_no_perf
      logic [CNT_W-1:0] unused_cnt;
      assign unused_cnt = '0;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
